// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the counter access arbiter: opcodes, FSM states
// and counter width.
package counter_ctrl_pkg;

    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_INC   = 2'b01,
        OP_LOAD  = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_e;

endpackage

// File: rtl/counter_access_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible bit at or above ptr_i,
// wrapping modulo N.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = $clog2(N)
) (
    input  logic [N-1:0]  elig_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [PW-1:0] idx_o,
    output logic          any_o
);

    always_comb begin
        int unsigned pos;
        logic [PW-1:0] j;
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        pos     = 0;
        j       = '0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = 32'(ptr_i) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            j = PW'(pos);
            if (!any_o && elig_i[j]) begin
                grant_o[j] = 1'b1;
                idx_o      = j;
                any_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_access_arbiter.sv
// Round-robin arbiter sequencing READ/INC/LOAD/CLEAR requests from NREQ
// requesters onto a shared 3-bit counter; all outputs registered.
module counter_access_arbiter
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned  NREQ  = 4,
    localparam int unsigned PTR_W = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [2*NREQ-1:0]       op,
    input  logic [CNT_W*NREQ-1:0]   wdata,
    output logic [NREQ-1:0]         ack,
    output logic [CNT_W-1:0]        rdata,
    output logic                    wrapped,
    output logic                    busy,
    output logic                    cnt_ld,
    output logic                    cnt_inc,
    output logic [CNT_W-1:0]        cnt_din,
    input  logic [CNT_W-1:0]        cnt_q
);

    state_e            state_q;
    logic [PTR_W-1:0]  rr_ptr_q;
    logic [NREQ-1:0]   mask_q;
    logic [NREQ-1:0]   win_oh_q;
    op_e               op_q;
    logic [CNT_W-1:0]  pre_q;

    logic [NREQ-1:0]   ack_q;
    logic [CNT_W-1:0]  rdata_q;
    logic              wrapped_q;
    logic              busy_q;
    logic              cnt_ld_q;
    logic              cnt_inc_q;
    logic [CNT_W-1:0]  cnt_din_q;

    logic [NREQ-1:0]   pick_grant;
    logic [PTR_W-1:0]  pick_idx;
    logic              pick_any;
    op_e               pick_op;
    logic [CNT_W-1:0]  pick_wdata;
    logic [PTR_W-1:0]  rr_ptr_d;

    rr_pick #(
        .N  (NREQ),
        .PW (PTR_W)
    ) u_pick (
        .elig_i  (req & ~mask_q),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    assign pick_op    = op_e'(op[pick_idx*2 +: 2]);
    assign pick_wdata = wdata[pick_idx*CNT_W +: CNT_W];
    assign rr_ptr_d   = (pick_idx == PTR_W'(NREQ - 1)) ? '0 : pick_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            mask_q    <= '0;
            win_oh_q  <= '0;
            op_q      <= OP_READ;
            pre_q     <= '0;
            ack_q     <= '0;
            rdata_q   <= '0;
            wrapped_q <= 1'b0;
            busy_q    <= 1'b0;
            cnt_ld_q  <= 1'b0;
            cnt_inc_q <= 1'b0;
            cnt_din_q <= '0;
        end else begin
            ack_q     <= '0;
            wrapped_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // Mask only ever blocks the single IDLE cycle right after an ack.
                    mask_q <= '0;
                    if (pick_any) begin
                        win_oh_q <= pick_grant;
                        op_q     <= pick_op;
                        pre_q    <= cnt_q;
                        rr_ptr_q <= rr_ptr_d;
                        busy_q   <= 1'b1;
                        state_q  <= ISSUE;
                        unique case (pick_op)
                            OP_INC:   cnt_inc_q <= 1'b1;
                            OP_LOAD: begin
                                cnt_ld_q  <= 1'b1;
                                cnt_din_q <= pick_wdata;
                            end
                            OP_CLEAR: begin
                                cnt_ld_q  <= 1'b1;
                                cnt_din_q <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                ISSUE: begin
                    cnt_ld_q  <= 1'b0;
                    cnt_inc_q <= 1'b0;
                    cnt_din_q <= '0;
                    state_q   <= RESP;
                end
                RESP: begin
                    ack_q     <= win_oh_q;
                    rdata_q   <= cnt_q;
                    wrapped_q <= (op_q == OP_INC) && (pre_q == 3'd7);
                    mask_q    <= win_oh_q;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack     = ack_q;
    assign rdata   = rdata_q;
    assign wrapped = wrapped_q;
    assign busy    = busy_q;
    assign cnt_ld  = cnt_ld_q;
    assign cnt_inc = cnt_inc_q;
    assign cnt_din = cnt_din_q;

endmodule

// File: tb/tb_counter_access_arbiter.sv
// Directed bench for counter_access_arbiter with a behavioural 3-bit counter
// attached to the strobe outputs.
module tb_counter_access_arbiter;

    localparam int unsigned NREQ = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [2*NREQ-1:0] op = '0;
    logic [3*NREQ-1:0] wdata = '0;
    logic [NREQ-1:0]   ack;
    logic [2:0]        rdata;
    logic              wrapped;
    logic              busy;
    logic              cnt_ld;
    logic              cnt_inc;
    logic [2:0]        cnt_din;
    logic [2:0]        cnt_q;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [NREQ-1:0] req;
        logic [1:0]      opc;
        logic [2:0]      wd;
        logic            exp_inc;
        logic            exp_ld;
        logic [2:0]      exp_din;
        logic [2:0]      exp_rdata;
        logic            exp_wr;
    } vec_t;

    vec_t tbl[10];

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (rst)          cnt_q <= '0;
        else if (cnt_ld)  cnt_q <= cnt_din;
        else if (cnt_inc) cnt_q <= cnt_q + 3'd1;
    end

    counter_access_arbiter #(.NREQ(NREQ)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .op      (op),
        .wdata   (wdata),
        .ack     (ack),
        .rdata   (rdata),
        .wrapped (wrapped),
        .busy    (busy),
        .cnt_ld  (cnt_ld),
        .cnt_inc (cnt_inc),
        .cnt_din (cnt_din),
        .cnt_q   (cnt_q)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".ack"},     int'(ack), 0);
        chk({tag, ".rdata"},   int'(rdata), 0);
        chk({tag, ".wrapped"}, int'(wrapped), 0);
        chk({tag, ".busy"},    int'(busy), 0);
        chk({tag, ".cnt_ld"},  int'(cnt_ld), 0);
        chk({tag, ".cnt_inc"}, int'(cnt_inc), 0);
        chk({tag, ".cnt_din"}, int'(cnt_din), 0);
    endtask

    task automatic txn(input vec_t v, input string tag);
        req   = v.req;
        op    = {NREQ{v.opc}};
        wdata = {NREQ{v.wd}};
        step();
        chk({tag, ".busy_issue"}, int'(busy), 1);
        chk({tag, ".cnt_inc"},    int'(cnt_inc), int'(v.exp_inc));
        chk({tag, ".cnt_ld"},     int'(cnt_ld), int'(v.exp_ld));
        chk({tag, ".cnt_din"},    int'(cnt_din), int'(v.exp_din));
        chk({tag, ".ack_issue"},  int'(ack), 0);
        step();
        chk({tag, ".strobes_resp"}, int'({cnt_ld, cnt_inc}), 0);
        chk({tag, ".ack_resp"},     int'(ack), 0);
        step();
        chk({tag, ".ack"},       int'(ack), int'(v.req));
        chk({tag, ".rdata"},     int'(rdata), int'(v.exp_rdata));
        chk({tag, ".wrapped"},   int'(wrapped), int'(v.exp_wr));
        chk({tag, ".busy_done"}, int'(busy), 0);
        req = '0;
        step();
        chk({tag, ".ack_after"}, int'(ack), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [NREQ-1:0] exp_ack;
        vec_t            v;

        //          req      op     wd    inc   ld    din   rdata wrapped
        tbl[0] = '{4'b0001, 2'b01, 3'd0, 1'b1, 1'b0, 3'd0, 3'd1, 1'b0};
        tbl[1] = '{4'b0010, 2'b10, 3'd6, 1'b0, 1'b1, 3'd6, 3'd6, 1'b0};
        tbl[2] = '{4'b0100, 2'b01, 3'd0, 1'b1, 1'b0, 3'd0, 3'd7, 1'b0};
        tbl[3] = '{4'b1000, 2'b01, 3'd0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b1};
        tbl[4] = '{4'b0001, 2'b10, 3'd5, 1'b0, 1'b1, 3'd5, 3'd5, 1'b0};
        tbl[5] = '{4'b0100, 2'b11, 3'd6, 1'b0, 1'b1, 3'd0, 3'd0, 1'b0};
        tbl[6] = '{4'b1000, 2'b00, 3'd4, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0};
        tbl[7] = '{4'b0010, 2'b10, 3'd7, 1'b0, 1'b1, 3'd7, 3'd7, 1'b0};
        tbl[8] = '{4'b0010, 2'b00, 3'd0, 1'b0, 1'b0, 3'd0, 3'd7, 1'b0};
        tbl[9] = '{4'b0001, 2'b11, 3'd0, 1'b0, 1'b1, 3'd0, 3'd0, 1'b0};

        do_reset();
        chk_all_zero("reset");

        for (int i = 0; i < 10; i++) begin
            txn(tbl[i], $sformatf("v%0d", i));
        end

        // Fairness: all four requesting READ, each re-raises after its mask cycle.
        do_reset();
        op    = '0;
        wdata = '0;
        req   = 4'b1111;
        step();
        for (int g = 0; g < 5; g++) begin
            exp_ack = '0;
            exp_ack[g % 4] = 1'b1;
            step();
            chk($sformatf("fair%0d.ack_early", g), int'(ack), 0);
            step();
            chk($sformatf("fair%0d.ack", g), int'(ack), int'(exp_ack));
            chk($sformatf("fair%0d.rdata", g), int'(rdata), 0);
            req = req & ~exp_ack;
            if (g == 4) req = '0;
            step();
            chk($sformatf("fair%0d.next_busy", g), int'(busy), (g == 4) ? 0 : 1);
            if (g != 4) req = req | exp_ack;
        end
        step();

        // Reset landing in the ISSUE cycle of a LOAD abandons it.
        v = '{4'b0010, 2'b10, 3'd5, 1'b0, 1'b1, 3'd5, 3'd5, 1'b0};
        txn(v, "preload");
        req   = 4'b0001;
        op    = {NREQ{2'b10}};
        wdata = {NREQ{3'd3}};
        step();
        chk("midrst.cnt_ld", int'(cnt_ld), 1);
        chk("midrst.cnt_din", int'(cnt_din), 3);
        rst = 1'b1;
        req = '0;
        step();
        chk_all_zero("midrst");
        rst = 1'b0;
        step();
        chk("midrst.ack_post1", int'(ack), 0);
        step();
        chk("midrst.ack_post2", int'(ack), 0);
        v = '{4'b1000, 2'b00, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0};
        txn(v, "midrst_read");

        // Held req: blocked for exactly the mask cycle, then re-granted.
        req = 4'b0001;
        op  = {NREQ{2'b01}};
        step();
        chk("held.inc1", int'(cnt_inc), 1);
        step();
        step();
        chk("held.ack1", int'(ack), 1);
        chk("held.rdata1", int'(rdata), 1);
        step();
        chk("held.mask_busy", int'(busy), 0);
        chk("held.mask_inc", int'(cnt_inc), 0);
        chk("held.mask_ack", int'(ack), 0);
        step();
        chk("held.regrant_busy", int'(busy), 1);
        chk("held.inc2", int'(cnt_inc), 1);
        step();
        step();
        chk("held.ack2", int'(ack), 1);
        chk("held.rdata2", int'(rdata), 2);
        req = '0;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/counter_access_arbiter.md
Name: counter_access_arbiter

Overview:
- Shares one 3-bit loadable/incrementing counter (ports ld, inc, data_in, data_out) among NREQ requesters.
- Round-robin arbitration; sequences one operation at a time onto the counter control pins; returns the post-operation counter value with a one-cycle ack.
- Sits beside the counter; the counter's clk and rst are tied to the same clk and rst as this block.

Parameters:
- NREQ, 4, number of requesters (2..8).
- PTR_W, $clog2(NREQ), round-robin pointer width (derived, not overridden).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester request; held high until ack
- op  in  2*NREQ  per-requester opcode (slice i = op[2i+1:2i]): 00 READ, 01 INC, 10 LOAD, 11 CLEAR
- wdata  in  3*NREQ  per-requester load value (slice i = wdata[3i+2:3i]); used only for LOAD
- ack  out  NREQ  one-hot, one-cycle completion pulse
- rdata  out  3  counter value after the operation; valid when any ack bit is high
- wrapped  out  1  high with ack when an INC moved the counter from 7 to 0
- busy  out  1  high in ISSUE and RESP
- cnt_ld  out  1  drives counter ld
- cnt_inc  out  1  drives counter inc
- cnt_din  out  3  drives counter data_in
- cnt_q  in  3  counter data_out

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; ack=0; rdata=0; wrapped=0; busy=0; cnt_ld=0; cnt_inc=0; cnt_din=0; rr_ptr=0; mask=0.
  - Reset mid-operation abandons the operation. No ack is issued; requesters re-request after reset.
- All outputs are registered.
- FSM states: IDLE, ISSUE, RESP.
  - IDLE: eligible = req & ~mask. If eligible≠0:
    - winner = first set bit searching upward from rr_ptr, wrapping modulo NREQ.
    - Latch winner index, op, wdata and cnt_q (as pre_q).
    - Set outputs for the next cycle:
      - INC: cnt_inc=1.
      - LOAD: cnt_ld=1, cnt_din=wdata.
      - CLEAR: cnt_ld=1, cnt_din=0.
      - READ: no strobe.
    - rr_ptr = (winner+1) mod NREQ. Go to ISSUE.
    - Then clear mask.
  - ISSUE (1 cycle): strobes are high this cycle; the counter updates at the closing edge. Next: cnt_ld=0, cnt_inc=0, cnt_din=0, and go to RESP.
  - RESP (1 cycle):
    - ack[winner]=1; rdata=cnt_q; wrapped = (op==INC && pre_q==3'd7).
    - mask = one-hot(winner), which blocks the same requester in the following IDLE cycle so it has time to drop req.
    - Next state: IDLE.
- Latency: req seen in IDLE at cycle T → strobe in T+1 → ack/rdata in T+2. Minimum repeat interval is 3 cycles.
- ld and inc are never high together; at most one strobe per operation.
- Requester rules:
  - op and wdata are held stable while req is high.
  - req drops in the cycle after ack. A req still high at that point is treated as a new request.
- req changes during ISSUE/RESP are ignored; only IDLE samples req.
- Width arithmetic: INC wraps modulo 8. pre_q is captured in IDLE so wrapped does not depend on counter timing.
- Simultaneous requests: exactly one is granted; the others stay pending and are not dropped.
- NREQ not a power of two: the pointer wraps at NREQ-1 → 0.

Decomposition:
- Shared package counter_ctrl_pkg:
  - op encodings: OP_READ, OP_INC, OP_LOAD, OP_CLEAR.
  - state enum: IDLE, ISSUE, RESP.
  - constant CNT_W=3.
- One sub-module: rr_pick.
  - Combinational round-robin priority picker.
  - Inputs: eligible vector, pointer. Outputs: one-hot grant, index, any_valid.
- FSM, latches and output registers stay in the top module.

Test Plan:
- Reset then single INC: rst 2 cycles; req[0]=1, op0=01 → cnt_inc=1 one cycle, ack[0] two cycles after sampling, rdata=1, wrapped=0.
- LOAD then wrap: req[1] LOAD wdata=6 → rdata=6. Then two INCs → rdata=7 with wrapped=0, then rdata=0 with wrapped=1.
- Fairness: req=4'b1111 held, each requester re-raising req after its mask cycle → ack order 0,1,2,3,0 with no repeats while others are pending. Each grant is 3 cycles apart.
- CLEAR and READ: counter at 5. Requester 2 CLEAR → cnt_ld=1, cnt_din=0, rdata=0. Requester 3 READ → no strobes, rdata=0.
- Reset mid-operation: assert rst in the ISSUE cycle of a LOAD with wdata=3 → no ack; next cycle all outputs are 0 and state is IDLE. Counter value is 0; a following READ returns 0.
- Held req: requester 0 keeps req high after ack with requester 1 idle → no grant in the mask cycle; re-granted one cycle later.
